// File: rtl/bus_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_op_sequencer_if
//  Description : Command handshake and bus/register strobe bundle between the
//                instruction decoder (master) and bus_op_sequencer (slave).
//                Command side : cmd_valid/cmd_ready, cmd_ra/rb/rc, cmd_imm,
//                               cmd_wide, cmd_op
//                Strobe side  : reg_out, c_out, zlow_out, zhigh_out (bus drive)
//                               reg_in, y_in, z_in, lo_in, hi_in (loads),
//                               alu_op, done
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_op_sequencer_if #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDXW-1:0]  cmd_ra;
    logic [IDXW-1:0]  cmd_rb;
    logic [IDXW-1:0]  cmd_rc;
    logic             cmd_imm;
    logic             cmd_wide;
    logic [OPW-1:0]   cmd_op;

    logic [NREGS-1:0] reg_out;
    logic             c_out;
    logic             zlow_out;
    logic             zhigh_out;
    logic [NREGS-1:0] reg_in;
    logic             y_in;
    logic             z_in;
    logic             lo_in;
    logic             hi_in;
    logic [OPW-1:0]   alu_op;
    logic             done;

    // Decoder side: issues commands, observes strobes.
    modport master (
        output cmd_valid, cmd_ra, cmd_rb, cmd_rc, cmd_imm, cmd_wide, cmd_op,
        input  cmd_ready,
        input  reg_out, c_out, zlow_out, zhigh_out,
        input  reg_in, y_in, z_in, lo_in, hi_in, alu_op, done
    );

    // Sequencer side: accepts commands, generates strobes.
    modport slave (
        input  cmd_valid, cmd_ra, cmd_rb, cmd_rc, cmd_imm, cmd_wide, cmd_op,
        output cmd_ready,
        output reg_out, c_out, zlow_out, zhigh_out,
        output reg_in, y_in, z_in, lo_in, hi_in, alu_op, done
    );
endinterface
`default_nettype wire

// File: rtl/bus_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bus_op_sequencer
//  Description : Micro-step controller for the shared 32-bit datapath bus.
//                Takes one ALU command (reg-reg or reg-imm, narrow or wide)
//                and emits, one bus source per cycle, the one-hot bus-drive
//                and register-load strobes:
//                  OPA : Rb -> Y
//                  OPB : Rc (or C) -> ALU, result -> Z
//                  WBL : ZLow -> Ra   (or -> LO when wide)
//                  WBH : ZHigh -> HI  (wide only)
//  Ports       : clock  - rising-edge clock
//                clear  - synchronous active-low reset
//                bus    - bus_op_sequencer_if.slave (command + strobes)
//  Option      : BUS_SEQ_PIPELINE_EN - accept the next command in the final
//                write-back cycle so commands run back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_op_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  wire logic         clock,
    input  wire logic         clear,
    bus_op_sequencer_if.slave bus
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPA  = 3'd1,
        ST_OPB  = 3'd2,
        ST_WBL  = 3'd3,
        ST_WBH  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] ra_q, ra_d;
    logic [IDXW-1:0] rb_q, rb_d;
    logic [IDXW-1:0] rc_q, rc_d;
    logic            imm_q, imm_d;
    logic            wide_q, wide_d;
    logic [OPW-1:0]  op_q, op_d;

    logic             w_ready;
    logic             w_accept;
    logic [NREGS-1:0] w_reg_out;
    logic             w_c_out;
    logic             w_zlow_out;
    logic             w_zhigh_out;
    logic [NREGS-1:0] w_reg_in;
    logic             w_y_in;
    logic             w_z_in;
    logic             w_lo_in;
    logic             w_hi_in;
    logic [OPW-1:0]   w_alu_op;
    logic             w_done;

    // Next state and Moore output decode.
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rc_d        = rc_q;
        imm_d       = imm_q;
        wide_d      = wide_q;
        op_d        = op_q;
        w_ready     = 1'b0;
        w_reg_out   = '0;
        w_c_out     = 1'b0;
        w_zlow_out  = 1'b0;
        w_zhigh_out = 1'b0;
        w_reg_in    = '0;
        w_y_in      = 1'b0;
        w_z_in      = 1'b0;
        w_lo_in     = 1'b0;
        w_hi_in     = 1'b0;
        w_alu_op    = '0;
        w_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_OPA: begin
                w_reg_out[rb_q] = 1'b1;
                w_y_in          = 1'b1;
                state_d         = ST_OPB;
            end
            ST_OPB: begin
                if (imm_q) begin
                    w_c_out = 1'b1;
                end else begin
                    w_reg_out[rc_q] = 1'b1;
                end
                w_z_in   = 1'b1;
                w_alu_op = op_q;
                state_d  = ST_WBL;
            end
            ST_WBL: begin
                w_zlow_out = 1'b1;
                if (wide_q) begin
                    w_lo_in = 1'b1;
                    state_d = ST_WBH;
                end else begin
                    w_reg_in[ra_q] = 1'b1;
                    w_done         = 1'b1;
                    state_d        = ST_IDLE;
`ifdef BUS_SEQ_PIPELINE_EN
                    w_ready        = 1'b1;
`endif
                end
            end
            ST_WBH: begin
                w_zhigh_out = 1'b1;
                w_hi_in     = 1'b1;
                w_done      = 1'b1;
                state_d     = ST_IDLE;
`ifdef BUS_SEQ_PIPELINE_EN
                w_ready     = 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A handshake overrides the transition out of whichever state is
        // ready (IDLE, or the final write-back cycle when pipelined).
        w_accept = bus.cmd_valid & w_ready;
        if (w_accept) begin
            ra_d    = bus.cmd_ra;
            rb_d    = bus.cmd_rb;
            rc_d    = bus.cmd_rc;
            imm_d   = bus.cmd_imm;
            wide_d  = bus.cmd_wide;
            op_d    = bus.cmd_op;
            state_d = ST_OPA;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            imm_q   <= 1'b0;
            wide_q  <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            imm_q   <= imm_d;
            wide_q  <= wide_d;
            op_q    <= op_d;
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.reg_out   = w_reg_out;
    assign bus.c_out     = w_c_out;
    assign bus.zlow_out  = w_zlow_out;
    assign bus.zhigh_out = w_zhigh_out;
    assign bus.reg_in    = w_reg_in;
    assign bus.y_in      = w_y_in;
    assign bus.z_in      = w_z_in;
    assign bus.lo_in     = w_lo_in;
    assign bus.hi_in     = w_hi_in;
    assign bus.alu_op    = w_alu_op;
    assign bus.done      = w_done;
endmodule
`default_nettype wire

// File: tb/tb_bus_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_op_sequencer
//  Description : Scoreboard bench for bus_op_sequencer. Each accepted command
//                is expanded into its expected per-cycle strobe pattern; a
//                monitor pops one pattern per busy cycle and compares it,
//                and expects an all-idle pattern otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_op_sequencer;
    localparam int c_nregs = 16;
    localparam int c_opw   = 5;
    localparam logic [4:0] c_op_add = 5'd3;
    localparam logic [4:0] c_op_mul = 5'd9;
`ifdef BUS_SEQ_PIPELINE_EN
    localparam bit c_pipe = 1'b1;
`else
    localparam bit c_pipe = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] ro;
        logic        c;
        logic        zl;
        logic        zh;
        logic [15:0] ri;
        logic        y;
        logic        z;
        logic        lo;
        logic        hi;
        logic [4:0]  op;
        logic        dn;
    } rec_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    bus_op_sequencer_if #(.NREGS(c_nregs), .OPW(c_opw)) bus ();

    bus_op_sequencer #(.NREGS(c_nregs), .OPW(c_opw)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   finished = 1'b0;

    // Expected strobe sequence of one command, straight from the micro-step
    // table: read Rb into Y, operand 2 into Z, then write back.
    task automatic push_cmd(input int ra, input int rb, input int rc,
                            input bit imm, input bit wide, input logic [4:0] op);
        rec_t r;
        r = '0; r.ro = 16'd1 << rb; r.y = 1'b1;
        sb.push_back(r);
        r = '0; r.z = 1'b1; r.op = op;
        if (imm) r.c = 1'b1; else r.ro = 16'd1 << rc;
        sb.push_back(r);
        r = '0; r.zl = 1'b1;
        if (wide) begin
            r.lo = 1'b1;
            sb.push_back(r);
            r = '0; r.zh = 1'b1; r.hi = 1'b1; r.dn = 1'b1;
            sb.push_back(r);
        end else begin
            r.ri = 16'd1 << ra; r.dn = 1'b1;
            sb.push_back(r);
        end
    endtask

    task automatic junk_fields();
        bus.cmd_ra   = 4'($urandom);
        bus.cmd_rb   = 4'($urandom);
        bus.cmd_rc   = 4'($urandom);
        bus.cmd_imm  = 1'($urandom);
        bus.cmd_wide = 1'($urandom);
        bus.cmd_op   = 5'($urandom);
    endtask

    // Present a command and hold it until the sequencer takes it.
    task automatic send(input int ra, input int rb, input int rc,
                        input bit imm, input bit wide, input logic [4:0] op);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_ra    = 4'(ra);
        bus.cmd_rb    = 4'(rb);
        bus.cmd_rc    = 4'(rc);
        bus.cmd_imm   = imm;
        bus.cmd_wide  = wide;
        bus.cmd_op    = op;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (bus.cmd_ready) begin
                @(posedge clock);
                push_cmd(ra, rb, rc, imm, wide, op);
                ok = 1'b1;
            end
        end
        #1;
        bus.cmd_valid = 1'b0;
        junk_fields();
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL accept_timeout: cmd_ready never seen, required acceptance within 20 cycles");
        end
    endtask

    // Monitor: one expected pattern per cycle, idle when nothing is pending.
    initial begin : monitor
        rec_t act, exp_r;
        logic exp_rdy;
        forever begin
            @(negedge clock);
            if (finished) break;
            if (mon_en) begin
                exp_rdy = (sb.size() == 0) || (c_pipe && sb.size() == 1);
                n_cmp++;
                if (bus.cmd_ready !== exp_rdy) begin
                    n_bad++;
                    $display("FAIL cmd_ready @%0t: got %b required %b", $time, bus.cmd_ready, exp_rdy);
                end
                exp_r = (sb.size() > 0) ? sb.pop_front() : rec_t'('0);
                act = {bus.reg_out, bus.c_out, bus.zlow_out, bus.zhigh_out,
                       bus.reg_in, bus.y_in, bus.z_in, bus.lo_in, bus.hi_in,
                       bus.alu_op, bus.done};
                n_cmp++;
                if (act !== exp_r) begin
                    n_bad++;
                    $display("FAIL strobes @%0t: got ro=%h c=%b zl=%b zh=%b ri=%h y=%b z=%b lo=%b hi=%b op=%h dn=%b required ro=%h c=%b zl=%b zh=%b ri=%h y=%b z=%b lo=%b hi=%b op=%h dn=%b",
                             $time, act.ro, act.c, act.zl, act.zh, act.ri, act.y, act.z, act.lo, act.hi, act.op, act.dn,
                             exp_r.ro, exp_r.c, exp_r.zl, exp_r.zh, exp_r.ri, exp_r.y, exp_r.z, exp_r.lo, exp_r.hi, exp_r.op, exp_r.dn);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int gap;
        // Reset held 3 edges with a command presented: must not be captured.
        bus.cmd_valid = 1'b1;
        junk_fields();
        clear = 1'b0;
        @(posedge clock); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        clear = 1'b1;
        repeat (3) begin @(posedge clock); #1; end

        // Directed cases.
        send(5, 2, 3, 1'b0, 1'b0, c_op_add);        // narrow reg-reg
        repeat (2) begin @(posedge clock); #1; end
        send(1, 4, 7, 1'b1, 1'b0, c_op_add);        // immediate
        repeat (4) begin @(posedge clock); #1; end
        send(0, 6, 7, 1'b0, 1'b1, c_op_mul);        // wide
        repeat (5) begin @(posedge clock); #1; end
        send(9, 9, 9, 1'b0, 1'b0, c_op_add);        // ra==rb==rc
        send(3, 10, 11, 1'b0, 1'b0, 5'd7);          // presented while busy
        send(15, 0, 1, 1'b1, 1'b1, 5'd12);          // wide presented while busy
        send(8, 15, 0, 1'b0, 1'b0, 5'd1);
        repeat (5) begin @(posedge clock); #1; end

        // Reset during OPB abandons the command.
        send(12, 13, 14, 1'b0, 1'b0, c_op_add);
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock);
        sb.delete();
        #1;
        clear = 1'b1;
        repeat (4) begin @(posedge clock); #1; end

        // Randomized traffic with random gaps.
        repeat (150) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clock); #1; end
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 1'($urandom), 1'($urandom), 5'($urandom));
        end

        repeat (8) @(posedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected cycles left unobserved, required 0", sb.size());
        end
        finished = 1'b1;
        @(negedge clock);
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bus_op_sequencer.md
Name: bus_op_sequencer

Overview:
- Micro-step controller for the 32-bit shared datapath bus.
- Accepts one register-register or register-immediate ALU command via a valid/ready handshake.
- Generates, one bus source per cycle, the one-hot bus-drive strobes (R0out..R15out, Cout, ZLowOut, ZHighOut) and the matching register-load strobes (Rin, Yin, Zin, LOin, HIin).
- Sits between instruction decode and the bus/register file/ALU.

Parameters:
- NREGS, 16, number of general registers; sets width of reg_out/reg_in and of the register index fields (log2 NREGS).
- OPW, 5, ALU opcode width passed through to alu_op.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ra  in  4  destination register index.
- cmd_rb  in  4  first source register index.
- cmd_rc  in  4  second source register index; ignored when cmd_imm=1.
- cmd_imm  in  1  second operand is the sign-extended constant (drive Cout).
- cmd_wide  in  1  64-bit result (mul/div): write LO then HI instead of Ra.
- cmd_op  in  OPW  ALU operation code.
- reg_out  out  NREGS  one-hot R0out..R15out.
- c_out  out  1  Cout strobe.
- zlow_out  out  1  ZLowOut strobe.
- zhigh_out  out  1  ZHighOut strobe.
- reg_in  out  NREGS  one-hot R0in..R15in.
- y_in  out  1  Y load.
- z_in  out  1  Z (64-bit) load.
- lo_in  out  1  LO load.
- hi_in  out  1  HI load.
- alu_op  out  OPW  ALU operation; valid only while z_in=1, else 0.
- done  out  1  one-cycle pulse in the final write-back cycle.

Behaviour:
- Handshake and capture:
  - Command fields are captured into internal registers on the rising edge where cmd_valid & cmd_ready.
  - Inputs are don't-care otherwise.
  - cmd_valid while busy is ignored; the command is not lost, because the requester holds it until cmd_ready.
- States: IDLE, OPA, OPB, WBL, WBH. State register updates on the rising edge. All outputs are decoded combinationally from state and the captured fields (Moore).
- IDLE:
  - cmd_ready=1; all strobes 0.
  - Handshake → OPA.
- OPA: reg_out[rb]=1, y_in=1 → OPB.
- OPB:
  - If imm: c_out=1, else reg_out[rc]=1.
  - z_in=1, alu_op=op → WBL.
- WBL:
  - zlow_out=1.
  - If wide: lo_in=1 → WBH.
  - Else: reg_in[ra]=1, done=1 → IDLE.
- WBH: zhigh_out=1, hi_in=1, done=1 → IDLE.
- Latency: handshake at edge k; done is high during cycle k+3 (narrow) or k+4 (wide). Next cmd_ready=1 in cycle k+4 / k+5.
- Invariants:
  - Exactly one bus-drive strobe in every non-IDLE cycle; none in IDLE.
  - At most one register-load strobe per cycle.
  - reg_out and reg_in are each one-hot or zero.
- ra==rb==rc is legal: reads precede the write by design, so no hazard logic is needed.
- Reset:
  - clear=0 at any edge forces IDLE and clears captured fields.
  - All outputs 0 except cmd_ready=1 from the cycle after that edge, including mid-operation (the partial operation is abandoned; no done).
  - clear has priority over the handshake.

Optional Feature:
- BUS_SEQ_PIPELINE_EN
  - Defined:
    - cmd_ready is also 1 in the final write-back cycle (WBL for narrow, WBH for wide).
    - A handshake there transitions directly to OPA, giving back-to-back commands with no IDLE bubble. Narrow throughput is one command per 3 cycles.
    - done still pulses for the completing command.
  - Undefined: cmd_ready=1 only in IDLE (baseline above).

Test Plan:
- Reset: hold clear=0 3 cycles with cmd_valid=1 → all strobes 0, cmd_ready=1, no capture; release and check no spurious done.
- Narrow reg op: ra=5, rb=2, rc=3, op=ADD → cycles k+1..k+3:
  - reg_out=0x0004 with y_in;
  - reg_out=0x0008 with z_in, alu_op=ADD;
  - zlow_out with reg_in=0x0020 and done.
  - Then IDLE.
- Immediate: ra=1, rb=4, imm=1, rc=7 → OPB asserts c_out=1, reg_out=0, never R7out.
- Wide mul: rb=6, rc=7, wide=1 → WBL: zlow_out+lo_in, reg_in=0; WBH: zhigh_out+hi_in+done; total 4 busy cycles.
- Busy backpressure: second command presented during OPA → cmd_ready=0 until IDLE; command accepted exactly once afterward. With BUS_SEQ_PIPELINE_EN, accepted in WBL and OPA follows immediately.
- Reset mid-op: clear=0 during OPB → next cycle IDLE, all strobes 0, no done, no reg_in pulse ever for that command.
